if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch.sv | 138 +++++++++++++
 tb/tb_if_prefetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch queue: fetches from a combinational instruction memory into a
// DEPTH-entry FIFO, with redirect/interrupt flush. Optional 0-cycle bypass via IF_PREFETCH_BYPASS_EN.
module if_prefetch #(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter int                 DEPTH      = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC   = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0]  INT_VECTOR = 32'h0000_0080
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              interrupt,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc4_out,
    output logic [ADDR_W-1:0] epc
);

    localparam int                PTR_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] FOUR     = ADDR_W'(3'b100);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] epc_r;
    logic [PTR_W-1:0]  headPtr_r;
    logic [PTR_W-1:0]  tailPtr_r;
    logic [PTR_W:0]    count_r;
    logic [DATA_W-1:0] qInstr_r [DEPTH];
    logic [ADDR_W-1:0] qPc4_r   [DEPTH];

    logic [ADDR_W-1:0] pcPlus4_s;
    logic              takeRedirect_s;
    logic              takeInt_s;
    logic              flush_s;
    logic              notEmpty_s;
    logic              full_s;
    logic              bypass_s;
    logic              valid_s;
    logic              pop_s;
    logic              push_s;
    logic [DATA_W-1:0] instr_s;
    logic [ADDR_W-1:0] pc4_s;

    // Control decode: flush priority, queue handshake and optional bypass path
    always_comb begin
        pcPlus4_s      = pc_r + FOUR;
        takeRedirect_s = redirect;
        takeInt_s      = interrupt & ~redirect;
        flush_s        = takeRedirect_s | takeInt_s;
        notEmpty_s     = (count_r != {(PTR_W + 1){1'b0}});
        full_s         = (count_r == CNT_FULL);
        bypass_s       = 1'b0;
`ifdef IF_PREFETCH_BYPASS_EN
        bypass_s       = ~reset & ~flush_s & ~notEmpty_s & id_ready;
`endif
        valid_s        = ~reset & ~flush_s & (notEmpty_s | bypass_s);
        pop_s          = valid_s & id_ready & notEmpty_s;
        // A full queue still accepts a fetch when the head leaves in the same cycle
        push_s         = ~reset & ~flush_s & ~bypass_s & (~full_s | pop_s);
    end

    // Output mux: queue head, bypassed fetch, or zeros when nothing is valid
    always_comb begin
        instr_s = {DATA_W{1'b0}};
        pc4_s   = {ADDR_W{1'b0}};
        if (valid_s) begin
            if (bypass_s) begin
                instr_s = imem_rdata;
                pc4_s   = pcPlus4_s;
            end else begin
                instr_s = qInstr_r[headPtr_r];
                pc4_s   = qPc4_r[headPtr_r];
            end
        end else begin
            instr_s = {DATA_W{1'b0}};
            pc4_s   = {ADDR_W{1'b0}};
        end
    end

    // PC, pointers, occupancy and exception PC
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r      <= RESET_PC;
            epc_r     <= {ADDR_W{1'b0}};
            headPtr_r <= {PTR_W{1'b0}};
            tailPtr_r <= {PTR_W{1'b0}};
            count_r   <= {(PTR_W + 1){1'b0}};
        end else if (flush_s) begin
            headPtr_r <= {PTR_W{1'b0}};
            tailPtr_r <= {PTR_W{1'b0}};
            count_r   <= {(PTR_W + 1){1'b0}};
            if (takeRedirect_s) begin
                pc_r <= redirect_addr;
            end else begin
                pc_r  <= INT_VECTOR;
                // Oldest unissued instruction is the head if one exists, else the fetch PC
                epc_r <= notEmpty_s ? (qPc4_r[headPtr_r] - FOUR) : pc_r;
            end
        end else begin
            if (push_s) begin
                tailPtr_r <= tailPtr_r + PTR_ONE;
            end
            if (pop_s) begin
                headPtr_r <= headPtr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (push_s | bypass_s) begin
                pc_r <= pcPlus4_s;
            end
        end
    end

    // Queue storage; contents are don't-care while the entry is not counted
    always_ff @(posedge clk) begin
        if (push_s) begin
            qInstr_r[tailPtr_r] <= imem_rdata;
            qPc4_r[tailPtr_r]   <= pcPlus4_s;
        end
    end

    assign imem_addr = pc_r;
    assign if_valid  = valid_s;
    assign instr_out = instr_s;
    assign pc4_out   = pc4_s;
    assign epc       = epc_r;

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: a queue-based reference model predicts each cycle's
// outputs; a monitor process pops and compares them against the DUT.
module tb_if_prefetch;

    localparam int          DEPTH      = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] INT_VECTOR = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        interrupt = 1'b0;
    logic        id_ready = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;
    logic [31:0] epc;

    int nChecks = 0;
    int nFail   = 0;

    if_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
                  .RESET_PC(RESET_PC), .INT_VECTOR(INT_VECTOR)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
        .interrupt(interrupt), .id_ready(id_ready), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .instr_out(instr_out),
        .pc4_out(pc4_out), .epc(epc));

    always #5 clk = ~clk;

    // Instruction memory: each word holds its own address
    assign imem_rdata = imem_addr;

    typedef struct { logic [31:0] instr; logic [31:0] pc4; } ent_t;
    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        known;
    } rec_t;

    ent_t        mq[$];
    rec_t        cycQ[$];
    logic [31:0] mPc = 32'h0;
    logic [31:0] mEpc = 32'h0;
    logic        mKnown = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, run the reference model, queue the expected outputs
    task automatic cyc(input logic r, input logic rd, input logic [31:0] ra,
                       input logic it, input logic rdy);
        rec_t rec;
        ent_t f;
        logic handled;
        logic wasFull;
        @(negedge clk);
        reset = r; redirect = rd; redirect_addr = ra; interrupt = it; id_ready = rdy;
        #2;
        rec.v = 1'b0; rec.instr = 32'h0; rec.pc4 = 32'h0;
        rec.pc = mPc; rec.epc = mEpc; rec.known = mKnown;
        if (r) begin
            mq.delete(); mPc = RESET_PC; mEpc = 32'h0; mKnown = 1'b1;
        end else if (rd) begin
            mq.delete(); mPc = ra;
        end else if (it) begin
            mEpc = (mq.size() != 0) ? mq[0].pc4 - 32'd4 : mPc;
            mq.delete(); mPc = INT_VECTOR;
        end else begin
            f.instr = mPc; f.pc4 = mPc + 32'd4;
            handled = 1'b0;
`ifdef IF_PREFETCH_BYPASS_EN
            if (mq.size() == 0 && rdy) begin
                rec.v = 1'b1; rec.instr = f.instr; rec.pc4 = f.pc4;
                mPc = f.pc4; handled = 1'b1;
            end
`endif
            if (!handled) begin
                wasFull = (mq.size() == DEPTH);
                rec.v = (mq.size() != 0);
                if (rec.v) begin
                    rec.instr = mq[0].instr; rec.pc4 = mq[0].pc4;
                end
                if (rec.v && rdy) void'(mq.pop_front());
                if (!wasFull || (rec.v && rdy)) begin
                    mq.push_back(f); mPc = f.pc4;
                end
            end
        end
        cycQ.push_back(rec);
    endtask

    // Monitor: compares DUT outputs against the expectation queued for this cycle
    always @(negedge clk) begin
        rec_t e;
        #3;
        if (cycQ.size() != 0) begin
            e = cycQ.pop_front();
            chk("if_valid", {31'h0, if_valid}, {31'h0, e.v});
            chk("instr_out", instr_out, e.instr);
            chk("pc4_out", pc4_out, e.pc4);
            if (e.known) begin
                chk("imem_addr", imem_addr, e.pc);
                chk("epc", epc, e.epc);
            end
        end
    end

    initial begin
        logic        r, rd, it, rdy;
        logic [31:0] ra;

        // Reset, then free-running fetch with memory word = address
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (8) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Decode stalled for 10 cycles: queue saturates, PC parks at 16
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall_pc16", imem_addr, 32'h10);
        repeat (8) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Redirect to 0x100 with 3 entries queued
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
        chk("redir_valid0", {31'h0, if_valid}, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("redir_fetch", imem_addr, 32'h100);
        repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Interrupt with head pc4 = 0x24, then interrupt coincident with redirect
        cyc(1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("int_epc", epc, 32'h20);
        chk("int_vector", imem_addr, INT_VECTOR);
        cyc(1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("intredir_fetch", imem_addr, 32'h200);
        chk("intredir_epc", epc, 32'h20);

        // Reset asserted in a redirect/interrupt cycle
        repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_redir_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_redir_pc", imem_addr, RESET_PC);

        // PC wrap through all-ones
        cyc(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(63) == 0);
            rd  = ($urandom_range(15) == 0);
            it  = ($urandom_range(15) == 0);
            rdy = ($urandom_range(9) < 6);
            ra  = ($urandom_range(7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            cyc(r, rd, ra, it, rdy);
        end

        @(negedge clk);
        #5;
        chk("scoreboard_drained", cycQ.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
